sha_result_checker: RTL

- Sits downstream of the SHA pipeline and consumes its result interface: the strobe, the 256-bit final hash H and the nonce that travels with it.
- Compares each hash against a loadable difficulty target.
- Queues winning ("golden") nonces in a small FIFO and drains them to the host/PS side over a valid/ready handshake.
- Keeps running counts of checked hashes and found nonces.

---
 rtl/sha_result_checker_pkg.sv | 23 ++
 rtl/sha_result_checker_if.sv | 14 +
 rtl/sha.vh | 11 +
 rtl/sha_nonce_fifo.sv | 43 ++++
 rtl/sha_result_checker.sv | 95 +++++++++
 5 files changed

// File: rtl/sha_result_checker_pkg.sv
// Types shared by the SHA result checker: hash/word widths and the pipeline stage records.
`include "sha.vh"

package sha_result_checker_pkg;

    localparam int WORD_W = `WORD_S;
    localparam int HASH_W = `H_SIZE;

    typedef logic [HASH_W-1:0] hash_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic  vld;
        hash_t h;
        word_t nonce;
    } s1_t;

    typedef struct packed {
        logic  hit;
        word_t nonce;
    } s2_t;

endpackage

// File: rtl/sha_result_checker_if.sv
// Result-side bus of the checker: the SHA pipeline strobe/hash/nonce in, golden nonces out.
`include "sha.vh"

interface sha_result_checker_if;
    logic                en;
    logic [`H_SIZE-1:0]  H;
    logic [`WORD_S-1:0]  nonce;
    logic [`WORD_S-1:0]  found_nonce;
    logic                found_valid;
    logic                found_ready;

    modport master (output en, H, nonce, found_ready, input found_nonce, found_valid);
    modport slave  (input en, H, nonce, found_ready, output found_nonce, found_valid);
endinterface

// File: rtl/sha.vh
// Shared SHA widths and helper macros.
// TARGET_RESET is the power-on difficulty target; BSWAP256 byte-reverses a 256-bit hash.
`ifndef SHA_VH
`define SHA_VH

`define WORD_S 32
`define H_SIZE 256
`define TARGET_RESET {`H_SIZE{1'b1}}
`define BSWAP256(x) {<<8{x}}

`endif

// File: rtl/sha_nonce_fifo.sv
// Small golden-nonce FIFO; DEPTH must be a power of two >= 2.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sha_nonce_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             wr_en, rd_en;

    // A push into a full queue still lands when the head leaves in the same cycle.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/sha_result_checker.sv
// Checks SHA results against a loadable target and queues winning nonces for the host.
// Build option SHA_CHECK_BSWAP_EN: byte-reverse H before the compare (Bitcoin hash order).
`include "sha.vh"

module sha_result_checker
    import sha_result_checker_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    sha_result_checker_if.slave   rif,
    input  logic                  target_we,
    input  hash_t                 target_in,
    input  logic                  clear_stats,
    output logic [CNT_W-1:0]      hashes_checked,
    output logic [CNT_W-1:0]      nonces_found,
    output logic                  overflow
);
    s1_t   s1;
    s2_t   s2;
    hash_t target;
    hash_t cmp_h;
    logic  fifo_full, fifo_empty, pop, drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
        end else begin
            s1.vld <= rif.en;
            if (rif.en) begin
                s1.h     <= rif.H;
                s1.nonce <= rif.nonce;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)          target <= `TARGET_RESET;
        else if (target_we) target <= target_in;
    end

`ifdef SHA_CHECK_BSWAP_EN
    assign cmp_h = `BSWAP256(s1.h);
`else
    assign cmp_h = s1.h;
`endif

    // Equality with the target is not a win.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2 <= '0;
        end else begin
            s2.hit   <= s1.vld && (cmp_h < target);
            s2.nonce <= s1.nonce;
        end
    end

    assign pop  = rif.found_ready && !fifo_empty;
    assign drop = s2.hit && fifo_full && !pop;

    sha_nonce_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s2.hit),
        .pop   (pop),
        .din   (s2.nonce),
        .dout  (rif.found_nonce),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rif.found_valid = !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset || clear_stats) hashes_checked <= '0;
        else if (rif.en)          hashes_checked <= hashes_checked + CNT_W'(1);
    end

    // Dropped winners still count as found.
    always_ff @(posedge clk) begin
        if (reset || clear_stats) nonces_found <= '0;
        else if (s2.hit)          nonces_found <= nonces_found + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)            overflow <= 1'b0;
        else if (drop)        overflow <= 1'b1;
        else if (clear_stats) overflow <= 1'b0;
    end
endmodule
